// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - round-robin writeback arbiter with per-source FIFOs, stall and pending masks
module core_wb_arbiter #(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int DEPTH = 2,
    parameter int RD_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0][RD_W-1:0]     in_rd,
    input  logic [N-1:0][W-1:0]        in_value,
    input  logic [N-1:0]               in_ready,
    output logic [RD_W-1:0]            wb_rd,
    output logic [W-1:0]               wb_value,
    output logic                       wb_ready,
    output logic [N-1:0]               stall,
    output logic [(1<<RD_W)-1:0]       pending,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

    logic [RD_W-1:0] fifo_rd_q  [N][DEPTH];
    logic [RD_W-1:0] fifo_rd_d  [N][DEPTH];
    logic [W-1:0]    fifo_val_q [N][DEPTH];
    logic [W-1:0]    fifo_val_d [N][DEPTH];
    logic [CW-1:0]   count_q [N];
    logic [CW-1:0]   count_d [N];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic [W-1:0]    wb_value_q, wb_value_d;
    logic            wb_ready_q, wb_ready_d;
    logic            overflow_q, overflow_d;

    logic            grant_valid;
    logic [PW-1:0]   grant_idx;
    logic [N-1:0]    nonempty;
    logic            pop;
    logic [CW-1:0]   fill;

    // Round-robin search from ptr+1, looking only at registered counts
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        nonempty    = '0;
        for (int i = 0; i < N; i++) begin
            nonempty[i] = (count_q[i] != '0);
        end
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!grant_valid && nonempty[i] && (((int'(ptr_q) + k) % N) == i)) begin
                    grant_valid = 1'b1;
                    grant_idx   = PW'(i);
                end
            end
        end
        ptr_d = grant_valid ? grant_idx : ptr_q;
    end

    // Shift-register FIFOs: head at index 0, a push lands behind the surviving entries
    always_comb begin
        fifo_rd_d  = fifo_rd_q;
        fifo_val_d = fifo_val_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop        = 1'b0;
        fill       = '0;
        for (int i = 0; i < N; i++) begin
            pop  = grant_valid && (grant_idx == PW'(i));
            fill = count_q[i] - CW'(pop);
            if (pop) begin
                for (int j = 0; j < DEPTH - 1; j++) begin
                    fifo_rd_d[i][j]  = fifo_rd_q[i][j+1];
                    fifo_val_d[i][j] = fifo_val_q[i][j+1];
                end
            end
            count_d[i] = fill;
            if (in_ready[i]) begin
                if ((count_q[i] != DEPTH_C) || pop) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (CW'(j) == fill) begin
                            fifo_rd_d[i][j]  = in_rd[i];
                            fifo_val_d[i][j] = in_value[i];
                        end
                    end
                    count_d[i] = fill + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wb_rd_d    = wb_rd_q;
        wb_value_d = wb_value_q;
        wb_ready_d = grant_valid;
        for (int i = 0; i < N; i++) begin
            if (grant_valid && (grant_idx == PW'(i))) begin
                wb_rd_d    = fifo_rd_q[i][0];
                wb_value_d = fifo_val_q[i][0];
            end
        end
    end

    always_comb begin
        stall   = '0;
        pending = '0;
        for (int i = 0; i < N; i++) begin
            stall[i] = (count_q[i] >= STALL_C);
            for (int j = 0; j < DEPTH; j++) begin
                if (CW'(j) < count_q[i]) begin
                    pending[fifo_rd_q[i][j]] = 1'b1;
                end
            end
        end
        if (wb_ready_q) begin
            pending[wb_rd_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= '0;
            end
            ptr_q      <= PW'(N - 1);
            wb_rd_q    <= '0;
            wb_value_q <= '0;
            wb_ready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            wb_rd_q    <= wb_rd_d;
            wb_value_q <= wb_value_d;
            wb_ready_q <= wb_ready_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage needs no reset: count gates every use of it
    always_ff @(posedge clk) begin
        fifo_rd_q  <= fifo_rd_d;
        fifo_val_q <= fifo_val_d;
    end

    assign wb_rd    = wb_rd_q;
    assign wb_value = wb_value_q;
    assign wb_ready = wb_ready_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb/tb_core_wb_arbiter.sv - scoreboard bench for core_wb_arbiter
module tb_core_wb_arbiter;

    localparam int W = 16;
    localparam int N = 3;
    localparam int DEPTH = 2;
    localparam int RD_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0][RD_W-1:0] in_rd;
    logic [N-1:0][W-1:0]    in_value;
    logic [N-1:0]           in_ready;
    logic [RD_W-1:0]        wb_rd;
    logic [W-1:0]           wb_value;
    logic                   wb_ready;
    logic [N-1:0]           stall;
    logic [(1<<RD_W)-1:0]   pending;
    logic                   overflow;

    core_wb_arbiter #(.W(W), .N(N), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_rd    (in_rd),
        .in_value (in_value),
        .in_ready (in_ready),
        .wb_rd    (wb_rd),
        .wb_value (wb_value),
        .wb_ready (wb_ready),
        .stall    (stall),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RD_W-1:0] rd;
        logic [W-1:0]    val;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [RD_W-1:0] rd, input logic [W-1:0] val, input int c);
        exp_t x;
        x.rd  = rd;
        x.val = val;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] rdy,
                         input logic [RD_W-1:0] r0, input logic [RD_W-1:0] r1, input logic [RD_W-1:0] r2,
                         input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2);
        in_ready    = rdy;
        in_rd[0]    = r0;
        in_rd[1]    = r1;
        in_rd[2]    = r2;
        in_value[0] = v0;
        in_value[1] = v1;
        in_value[2] = v2;
        tick();
    endtask

    task automatic idle(input int n);
        in_ready = '0;
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (wb_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wb: got rd=%0d value=0x%0h at cycle %0d, required no output", wb_rd, wb_value, cyc);
            end else begin
                e = sb.pop_front();
                check("wb_rd", int'(wb_rd), int'(e.rd));
                check("wb_value", int'(wb_value), int'(e.val));
                check("wb_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_ready = '0;
        in_rd    = '0;
        in_value = '0;

        // Reset held two cycles while source 0 tries to push
        in_ready    = 3'b001;
        in_rd[0]    = 4'd3;
        in_value[0] = 16'hdead;
        tick();
        tick();
        check("rst_wb_ready", int'(wb_ready), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(1);

        base = cyc;
        sb_push(4'd3, 16'h1234, base + 2);
        drive(3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0, 16'h0);
        idle(4);

        // Round-robin from a fresh pointer, two back-to-back bursts
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        base = cyc;
        sb_push(4'd1, 16'h0101, base + 2);
        sb_push(4'd2, 16'h0202, base + 3);
        sb_push(4'd3, 16'h0303, base + 4);
        sb_push(4'd1, 16'h0111, base + 5);
        sb_push(4'd2, 16'h0212, base + 6);
        sb_push(4'd3, 16'h0313, base + 7);
        drive(3'b111, 4'd1, 4'd2, 4'd3, 16'h0101, 16'h0202, 16'h0303);
        drive(3'b111, 4'd1, 4'd2, 4'd3, 16'h0111, 16'h0212, 16'h0313);
        idle(8);

        // Source 1 pushes three cycles in a row under contention
        base = cyc;
        sb_push(4'd4, 16'h0a00, base + 2);
        sb_push(4'd6, 16'h1a00, base + 3);
        sb_push(4'd7, 16'h2a00, base + 4);
        sb_push(4'd4, 16'h0b00, base + 5);
        sb_push(4'd6, 16'h1b00, base + 6);
        sb_push(4'd6, 16'h1c00, base + 7);
        drive(3'b111, 4'd4, 4'd6, 4'd7, 16'h0a00, 16'h1a00, 16'h2a00);
        check("stall_count1", int'(stall), 3'b111);
        drive(3'b011, 4'd4, 4'd6, 4'd0, 16'h0b00, 16'h1b00, 16'h0);
        check("stall_full", int'(stall), 3'b111);
        drive(3'b010, 4'd0, 4'd6, 4'd0, 16'h0, 16'h1c00, 16'h0);
        check("stall_pushpop", int'(stall[1]), 1);
        idle(8);
        check("stall_drained", int'(stall), 0);
        check("no_overflow", int'(overflow), 0);

        base = cyc;
        sb_push(4'd7, 16'h0777, base + 2);
        drive(3'b100, 4'd0, 4'd0, 4'd7, 16'h0, 16'h0, 16'h0777);
        idle(4);

        // Third back-to-back push to source 2 hits a full FIFO
        base = cyc;
        sb_push(4'd8, 16'h0800, base + 2);
        sb_push(4'd9, 16'h0900, base + 3);
        sb_push(4'd10, 16'h0a01, base + 4);
        sb_push(4'd10, 16'h0a02, base + 5);
        drive(3'b111, 4'd8, 4'd9, 4'd10, 16'h0800, 16'h0900, 16'h0a01);
        check("ovf_before1", int'(overflow), 0);
        drive(3'b100, 4'd0, 4'd0, 4'd10, 16'h0, 16'h0, 16'h0a02);
        check("ovf_before2", int'(overflow), 0);
        drive(3'b100, 4'd0, 4'd0, 4'd10, 16'h0, 16'h0, 16'h0a03);
        check("ovf_set", int'(overflow), 1);
        idle(8);
        check("ovf_sticky", int'(overflow), 1);

        // Two writers to rd 5
        check("pend_idle", int'(pending), 0);
        base = cyc;
        sb_push(4'd5, 16'h0505, base + 2);
        sb_push(4'd5, 16'h0506, base + 3);
        drive(3'b011, 4'd5, 4'd5, 4'd0, 16'h0505, 16'h0506, 16'h0);
        check("pend_queued", int'(pending), 32'h0020);
        idle(1);
        check("pend_first_wb", int'(pending), 32'h0020);
        idle(1);
        check("pend_second_wb", int'(pending), 32'h0020);
        idle(1);
        check("pend_clear", int'(pending), 0);
        check("hold_rd", int'(wb_rd), 5);
        check("hold_value", int'(wb_value), 16'h0506);
        check("hold_ready", int'(wb_ready), 0);
        idle(3);

        // Reset with every FIFO occupied
        base = cyc;
        sb_push(4'd13, 16'h0e01, base + 2);
        drive(3'b111, 4'd11, 4'd12, 4'd13, 16'h0c01, 16'h0d01, 16'h0e01);
        drive(3'b111, 4'd11, 4'd12, 4'd13, 16'h0c02, 16'h0d02, 16'h0e02);
        rst_n = 1'b0;
        tick();
        check("mid_rst_wb_ready", int'(wb_ready), 0);
        check("mid_rst_stall", int'(stall), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(8);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
